// File: rtl/elastic_pipereg.sv
// Elastic valid/ready stage register with flush and a saturating stall counter.
// MODE 0 is a two-entry skid buffer (registered in_ready); MODE 1 is a single entry.
module elastic_pipereg #(
  parameter int unsigned     WIDTH     = 64,
  parameter int unsigned     MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic             in_fire, out_fire;

  // MODE 1 ready looks through to out_ready so a full entry can be replaced in one cycle
  always_comb begin
    if (MODE == 0) in_ready = ~skid_valid_q;
    else           in_ready = ~main_valid_q | out_ready;
  end

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = 2'(main_valid_q) + 2'(skid_valid_q);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    stall_cnt_d  = stall_cnt_q;

    if (main_valid_q && !out_ready && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (flush) begin
      // Data registers keep their contents; only the valids are killed
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (MODE == 0) begin
      if (out_fire) begin
        if (skid_valid_q) begin
          main_data_d  = skid_data_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          main_data_d  = in_data;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        if (main_valid_q) begin
          skid_data_d  = in_data;
          skid_valid_d = 1'b1;
        end else begin
          main_data_d  = in_data;
          main_valid_d = 1'b1;
        end
      end
    end else begin
      skid_valid_d = 1'b0;
      if (in_fire) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RESET_VAL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= RESET_VAL;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipereg.sv
// Directed bench for elastic_pipereg: skid-buffer streaming, backpressure, flush,
// async reset, single-entry mode and counter saturation.
module tb_elastic_pipereg;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  // Skid-buffer instance under main test
  logic        rst0, iv0, ir0, ov0, or0, fl0;
  logic [63:0] id0, od0;
  logic [1:0]  occ0;
  logic [15:0] sc0;

  // Single-entry instance
  logic        rst1, iv1, ir1, ov1, or1, fl1;
  logic [63:0] id1, od1;
  logic [1:0]  occ1;
  logic [15:0] sc1;

  // Narrow-counter instance for saturation
  logic        rst2, iv2, ir2, ov2, or2, fl2;
  logic [7:0]  id2, od2;
  logic [1:0]  occ2;
  logic [3:0]  sc2;

  elastic_pipereg #(.WIDTH(64), .MODE(0), .RESET_VAL(64'hDEAD), .CNT_W(16)) u0 (
    .clk(clk), .reset(rst0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .flush(fl0),
    .occupancy(occ0), .stall_cnt(sc0));

  elastic_pipereg #(.WIDTH(64), .MODE(1), .RESET_VAL(64'h0), .CNT_W(16)) u1 (
    .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(fl1),
    .occupancy(occ1), .stall_cnt(sc1));

  elastic_pipereg #(.WIDTH(8), .MODE(0), .RESET_VAL(8'h0), .CNT_W(4)) u2 (
    .clk(clk), .reset(rst2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(fl2),
    .occupancy(occ2), .stall_cnt(sc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst0 = 1; iv0 = 0; id0 = '0; or0 = 0; fl0 = 0;
    rst1 = 1; iv1 = 0; id1 = '0; or1 = 0; fl1 = 0;
    rst2 = 1; iv2 = 0; id2 = '0; or2 = 0; fl2 = 0;
    #1;
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_in_ready", 64'(ir0), 64'd1);
    chk("rst_out_data", od0, 64'hDEAD);
    chk("rst_occupancy", 64'(occ0), 64'd0);
    chk("rst_stall_cnt", 64'(sc0), 64'd0);
    chk("rst_in_ready_m1", 64'(ir1), 64'd1);
    #2;
    rst0 = 0; rst1 = 0; rst2 = 0;

    // Streaming 0x1..0x8 with out_ready held high
    or0 = 1;
    for (int i = 1; i <= 8; i++) begin
      iv0 = 1; id0 = 64'(i);
      tick();
      chk("stream_valid", 64'(ov0), 64'd1);
      chk("stream_data", od0, 64'(i));
      chk("stream_occ", 64'(occ0), 64'd1);
      chk("stream_ready", 64'(ir0), 64'd1);
    end
    iv0 = 0;
    tick();
    chk("drain_valid", 64'(ov0), 64'd0);
    chk("drain_occ", 64'(occ0), 64'd0);
    chk("drain_hold_data", od0, 64'h8);
    chk("stream_stall_cnt", 64'(sc0), 64'd0);

    // Backpressure: A to main, B to skid, C held upstream
    or0 = 0; iv0 = 1; id0 = 64'hA;
    tick();
    chk("bp_a_occ", 64'(occ0), 64'd1);
    chk("bp_a_ready", 64'(ir0), 64'd1);
    id0 = 64'hB;
    tick();
    chk("bp_b_occ", 64'(occ0), 64'd2);
    chk("bp_b_ready", 64'(ir0), 64'd0);
    chk("bp_b_data", od0, 64'hA);
    id0 = 64'hC;
    tick();
    chk("bp_hold_data", od0, 64'hA);
    chk("bp_hold_occ", 64'(occ0), 64'd2);
    tick();
    chk("bp_stall_cnt", 64'(sc0), 64'd3);
    or0 = 1;
    tick();
    chk("bp_out_b", od0, 64'hB);
    chk("bp_ready_back", 64'(ir0), 64'd1);
    chk("bp_occ_1", 64'(occ0), 64'd1);
    tick();
    chk("bp_out_c", od0, 64'hC);
    chk("bp_out_c_valid", 64'(ov0), 64'd1);
    iv0 = 0;
    tick();
    chk("bp_empty", 64'(ov0), 64'd0);
    chk("bp_stall_final", 64'(sc0), 64'd3);

    // Flush with two entries held and D offered
    or0 = 0; iv0 = 1; id0 = 64'h11;
    tick();
    id0 = 64'h12;
    tick();
    chk("fl_full_occ", 64'(occ0), 64'd2);
    fl0 = 1; id0 = 64'hD;
    tick();
    fl0 = 0; iv0 = 0;
    chk("fl_valid", 64'(ov0), 64'd0);
    chk("fl_occ", 64'(occ0), 64'd0);
    chk("fl_ready", 64'(ir0), 64'd1);
    chk("fl_data_kept", od0, 64'h11);
    chk("fl_stall_kept", 64'(sc0), 64'd5);
    or0 = 1;
    tick();
    chk("fl_no_d", 64'(ov0), 64'd0);

    // Flush discards an in_fire in the same cycle
    iv0 = 1; id0 = 64'h21;
    tick();
    chk("fl2_loaded", od0, 64'h21);
    fl0 = 1; id0 = 64'hD;
    tick();
    fl0 = 0; iv0 = 0;
    chk("fl2_valid", 64'(ov0), 64'd0);
    chk("fl2_occ", 64'(occ0), 64'd0);
    tick();
    chk("fl2_no_d", 64'(ov0), 64'd0);

    // Async reset with two entries held
    or0 = 0; iv0 = 1; id0 = 64'h31;
    tick();
    id0 = 64'h32;
    tick();
    chk("rs_occ_pre", 64'(occ0), 64'd2);
    chk("rs_stall_pre", 64'(sc0), 64'd6);
    rst0 = 1;
    #1;
    chk("rs_valid", 64'(ov0), 64'd0);
    chk("rs_data", od0, 64'hDEAD);
    chk("rs_occ", 64'(occ0), 64'd0);
    chk("rs_stall", 64'(sc0), 64'd0);
    chk("rs_ready", 64'(ir0), 64'd1);
    #1;
    rst0 = 0; or0 = 1; id0 = 64'h41;
    tick();
    chk("rs_first_data", od0, 64'h41);
    chk("rs_first_valid", 64'(ov0), 64'd1);
    iv0 = 0;

    // Single-entry mode: full main replaced in the same cycle it drains
    or1 = 0; iv1 = 1; id1 = 64'h4;
    tick();
    chk("m1_load", od1, 64'h4);
    chk("m1_occ", 64'(occ1), 64'd1);
    id1 = 64'h5;
    #1;
    chk("m1_ready_low", 64'(ir1), 64'd0);
    or1 = 1;
    #1;
    chk("m1_ready_comb", 64'(ir1), 64'd1);
    tick();
    chk("m1_next_data", od1, 64'h5);
    chk("m1_next_valid", 64'(ov1), 64'd1);
    iv1 = 0;
    tick();
    chk("m1_empty", 64'(ov1), 64'd0);
    chk("m1_empty_occ", 64'(occ1), 64'd0);

    // Saturating 4-bit stall counter
    iv2 = 1; id2 = 8'h5A; or2 = 0;
    tick();
    iv2 = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_mid", 64'(sc2), 64'd10);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_max", 64'(sc2), 64'd15);
    chk("sat_data_held", 64'(od2), 64'h5A);
    chk("sat_valid_held", 64'(ov2), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elastic_pipereg.md
# elastic_pipereg

Parametrised elastic pipeline register for the five-stage core. It replaces the plain clocked stage register between fetch/decode/execute/memory/writeback with a valid/ready handshake, synchronous flush and a stall-cycle counter. Two modes are available: a two-entry skid buffer, which gives full throughput and a registered in_ready, and a single-entry register, which gives full throughput through a combinational ready path. It is instantiated once per stage boundary, with WIDTH set to the stage payload struct width.

## Interface
- WIDTH, 64, payload width in bits (a packed stage struct)
- MODE, 0, 0 = two-entry skid buffer; 1 = single-entry register
- RESET_VAL, '0, value of every data register at reset
- CNT_W, 16, width of the saturating stall counter
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  block accepts a payload this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  payload presented downstream
- out_ready  in  1  downstream accepts this cycle
- out_data  out  WIDTH  downstream payload
- flush  in  1  synchronous kill of all held entries (branch or exception redirect)
- occupancy  out  2  entries held: 0..1 in MODE 1, 0..2 in MODE 0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State: main entry (main_valid, main_data). MODE 0 adds a skid entry (skid_valid, skid_data).
- Outputs: out_valid = main_valid; out_data = main_data.
- When main_valid=0, out_data holds the last payload it carried, or RESET_VAL after reset.
- MODE 0, in_ready = ~skid_valid. This is a pure register output with no combinational path from out_ready.
- MODE 0 next-state:
  - out_fire & skid_valid: main <= skid; skid cleared. An in_fire cannot occur in this case.
  - out_fire & ~skid_valid: main <= in_data if in_fire, else main_valid <= 0.
  - ~out_fire & main_valid & in_fire: skid <= in_data.
  - ~main_valid & in_fire: main <= in_data.
- MODE 1:
  - in_ready = ~main_valid | out_ready.
  - in_fire loads main.
  - out_fire without in_fire clears main_valid.
- Flush has the highest priority. The next cycle has all valids 0 and occupancy 0.
  - An in_fire in the same cycle as flush is discarded; upstream is flushed by the same redirect.
  - Data registers are not cleared by flush.
  - stall_cnt is unaffected by flush.
- Ordering is strictly FIFO. No payload is ever duplicated or dropped except by flush or reset.
- stall_cnt increments when out_valid & ~out_ready, and saturates at 2^CNT_W-1.

## Timing
- Reset (asynchronous, takes effect immediately):
  - main_valid = skid_valid = 0; out_valid = 0.
  - in_ready = 1 in both modes.
  - out_data = RESET_VAL; occupancy = 0; stall_cnt = 0.
- Latency: a payload accepted on edge N appears on out_data/out_valid after edge N, i.e. 1 cycle. It is never combinationally forwarded.
- Throughput: 1 payload/cycle in both modes while out_ready = 1.
- MODE 0 backpressure:
  - With main full and out_ready = 0, one more payload is accepted into skid.
  - in_ready drops the cycle after the skid fills.
  - in_ready rises the cycle after the skid drains.
- Handshake rules:
  - Upstream must hold in_data stable while in_valid=1 & in_ready=0.
  - The block holds out_data stable while out_valid=1 & out_ready=0.
- Reset deasserted mid-stream: the first in_fire is accepted on the first edge after deassertion.
- Counter wrap: no wrap. stall_cnt stays at its maximum value.

## Test plan
- Streaming: MODE 0, WIDTH 64, out_ready = 1, inputs 0x1..0x8 back-to-back -> outputs 0x1..0x8 on consecutive cycles, 1-cycle latency, occupancy = 1 throughout, stall_cnt = 0.
- Backpressure: MODE 0, send 0xA, 0xB, 0xC while out_ready = 0 -> 0xA in main, 0xB in skid, in_ready = 0, 0xC held upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order; stall_cnt equals the stalled cycles.
- Flush: MODE 0, occupancy = 2, assert flush together with in_valid = 1 (0xD) -> next cycle out_valid = 0, occupancy = 0, in_ready = 1, 0xD never appears.
- Single-entry mode: MODE 1, main full, out_ready = 1, in_valid = 1 (0x5) in the same cycle -> in_ready = 1 combinationally; 0x5 is on out_data the next cycle.
- Reset mid-stream and saturation: assert reset asynchronously with occupancy = 2 -> out_valid = 0 and out_data = RESET_VAL immediately. CNT_W = 4 with 20 stall cycles -> stall_cnt = 15.
